// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C transfer sequencer
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR_FETCH,
    S_WR_BYTE,
    S_RD_BYTE,
    S_RD_HOLD,
    S_STOP,
    S_FIN
  } i2c_seq_state_e;

  // Bit position of the R/nW flag inside the address byte (LSB on the wire).
  localparam int   RW_BIT_POS = 0;
  // Level of the ACK bit as returned by / driven to the byte controller.
  localparam logic ACK_BIT    = 1'b0;
  localparam logic NACK_BIT   = 1'b1;

  // Builds the first byte of a transfer: 7-bit address followed by R/nW.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rnw);
    logic [7:0] b;
    b = {addr, 1'b0};
    b[RW_BIT_POS] = rnw;
    return b;
  endfunction

endpackage

// File: rtl/i2c_xfer_seq.sv
// rtl/i2c_xfer_seq.sv - sequences START/address/data/STOP commands for one I2C transfer
module i2c_xfer_seq
  import i2c_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [6:0]       req_addr_i,
  input  logic             req_rnw_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [7:0]       tx_data_i,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [7:0]       rx_data_o,
  output logic             done_o,
  output logic             nack_o,
  output logic             al_o,
  output logic             bc_start_o,
  output logic             bc_stop_o,
  output logic             bc_read_o,
  output logic             bc_write_o,
  output logic             bc_ack_o,
  output logic [7:0]       bc_din_o,
  input  logic             bc_done_i,
  input  logic             bc_ack_i,
  input  logic [7:0]       bc_dout_i,
  input  logic             bc_al_i
);

  i2c_seq_state_e   state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic [7:0]       din_q, din_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             nack_q, nack_d;
  logic             al_q, al_d;
  // Output flops; their next values are decoded from the next state so every
  // command level changes exactly on the edge where the state changes.
  logic req_ready_q, req_ready_d;
  logic tx_ready_q, tx_ready_d;
  logic rx_valid_q, rx_valid_d;
  logic done_q, done_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic read_q, read_d;
  logic write_q, write_d;
  logic ack_q, ack_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rnw_d     = rnw_q;
    din_d     = din_q;
    rx_data_d = rx_data_q;
    nack_d    = nack_q;
    al_d      = al_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          rnw_d   = req_rnw_i;
          cnt_d   = req_len_i;
          din_d   = addr_byte(req_addr_i, req_rnw_i);
          nack_d  = 1'b0;
          al_d    = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bc_done_i) begin
          if (bc_ack_i == NACK_BIT) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = rnw_q ? S_RD_BYTE : S_WR_FETCH;
          end
        end
      end
      S_WR_FETCH: begin
        if (tx_valid_i && tx_ready_q) begin
          din_d   = tx_data_i;
          state_d = S_WR_BYTE;
        end
      end
      S_WR_BYTE: begin
        if (bc_done_i) begin
          if (cnt_q == '0) begin
            nack_d  = bc_ack_i;
            state_d = S_FIN;
          end else if (bc_ack_i == NACK_BIT) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = S_WR_FETCH;
          end
        end
      end
      S_RD_BYTE: begin
        if (bc_done_i) begin
          rx_data_d = bc_dout_i;
          state_d   = S_RD_HOLD;
        end
      end
      S_RD_HOLD: begin
        // Next read waits for the consumer; the idle byte controller stretches SCL.
        if (rx_ready_i) begin
          if (cnt_q == '0) begin
            state_d = S_FIN;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = S_RD_BYTE;
          end
        end
      end
      S_STOP: begin
        if (bc_done_i) state_d = S_FIN;
      end
      S_FIN: begin
        // A late arbitration loss is still reported but must not stretch done.
        if (bc_al_i) al_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus lost: abandon everything without a STOP; wins over a same-cycle done.
    if (bc_al_i && state_q != S_IDLE && state_q != S_FIN) begin
      cnt_d     = cnt_q;
      din_d     = din_q;
      rx_data_d = rx_data_q;
      nack_d    = nack_q;
      al_d      = 1'b1;
      state_d   = S_FIN;
    end

    req_ready_d = (state_d == S_IDLE);
    tx_ready_d  = (state_d == S_WR_FETCH);
    rx_valid_d  = (state_d == S_RD_HOLD);
    done_d      = (state_d == S_FIN);
    start_d     = (state_d == S_ADDR);
    write_d     = (state_d == S_ADDR) || (state_d == S_WR_BYTE);
    read_d      = (state_d == S_RD_BYTE);
    ack_d       = (state_d == S_RD_BYTE) && (cnt_d == '0);
    stop_d      = (state_d == S_STOP) ||
                  (((state_d == S_WR_BYTE) || (state_d == S_RD_BYTE)) && (cnt_d == '0));
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rnw_q       <= 1'b0;
      din_q       <= '0;
      rx_data_q   <= '0;
      nack_q      <= 1'b0;
      al_q        <= 1'b0;
      req_ready_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rnw_q       <= rnw_d;
      din_q       <= din_d;
      rx_data_q   <= rx_data_d;
      nack_q      <= nack_d;
      al_q        <= al_d;
      req_ready_q <= req_ready_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      read_q      <= read_d;
      write_q     <= write_d;
      ack_q       <= ack_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign tx_ready_o  = tx_ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign done_o      = done_q;
  assign nack_o      = nack_q;
  assign al_o        = al_q;
  assign bc_start_o  = start_q;
  assign bc_stop_o   = stop_q;
  assign bc_read_o   = read_q;
  assign bc_write_o  = write_q;
  assign bc_ack_o    = ack_q;
  assign bc_din_o    = din_q;

endmodule
